// File: rtl/phase_tracker_pkg.sv
// Shared definitions for the phase tracker loop.
//   lock_state_e  : lock FSM state encoding (IDLE / ACQUIRE / LOCKED)
//   DEF_*         : default widths, loop gains, thresholds and counts
//   cnt_width()   : width of a counter that must reach the larger of two counts
package phase_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } lock_state_e;

  localparam int DEF_NB_DATA            = 16;
  localparam int DEF_NB_PHASE           = 16;
  localparam int DEF_NB_INTEG           = 24;
  localparam int DEF_KP_SHIFT           = 4;
  localparam int DEF_KI_SHIFT           = 10;
  localparam int DEF_LOCKED_EXTRA_SHIFT = 2;
  localparam int DEF_LOCK_CNT           = 64;
  localparam int DEF_UNLOCK_CNT         = 8;

  localparam logic [DEF_NB_PHASE-1:0] DEF_INIT_PHASE = 16'h0CCC;
  localparam logic [DEF_NB_DATA-1:0]  DEF_LOCK_THR   = 16'h0400;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/phase_tracker_lock_detector.sv
// Lock detector: consecutive-sample counters, IDLE/ACQUIRE/LOCKED FSM and
// the registered lock flag.
//   i_clk, i_rst_n : clock, async active-low reset (already release-synchronised)
//   i_enable       : loop enable; low forces IDLE and clears the counter
//   i_clear        : synchronous clear; returns to ACQUIRE (enabled) or IDLE
//   i_sample       : an accepted sample this cycle
//   i_in_thr       : |err| of that sample is below the lock threshold
//   o_lock         : registered, high exactly while in LOCKED
//   o_dbg_state    : current FSM state (also used by the datapath for gain selection)
module lock_detector
  import phase_tracker_pkg::*;
#(
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int UNLOCK_CNT = DEF_UNLOCK_CNT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_clear,
  input  logic        i_sample,
  input  logic        i_in_thr,
  output logic        o_lock,
  output lock_state_e o_dbg_state
);

  localparam int CW = cnt_width(LOCK_CNT, UNLOCK_CNT);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_CNT - 1);
  localparam logic [CW-1:0] UNLOCK_LAST = CW'(UNLOCK_CNT - 1);

  lock_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic          lock_q;

  // A sample accepted while still in IDLE (enable rose this cycle) is
  // counted as an ACQUIRE sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
    end else if (i_clear) begin
      state_q <= i_enable ? ST_ACQUIRE : ST_IDLE;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
    end else if (!i_enable) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACQUIRE: begin
          state_q <= ST_ACQUIRE;
          if (i_sample) begin
            if (!i_in_thr) begin
              cnt_q <= '0;
            end else if (cnt_q == LOCK_LAST) begin
              state_q <= ST_LOCKED;
              cnt_q   <= '0;
              lock_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (i_sample) begin
            if (i_in_thr) begin
              cnt_q <= '0;
            end else if (cnt_q == UNLOCK_LAST) begin
              state_q <= ST_ACQUIRE;
              cnt_q   <= '0;
              lock_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          lock_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_lock      = lock_q;
  assign o_dbg_state = state_q;

endmodule

// File: rtl/phase_tracker.sv
// Decision-directed carrier phase tracker (PI loop).
// Handshake: a sample is accepted on a rising edge where i_valid=1,
// i_enable=1 and i_clear=0; exactly one cycle later o_valid pulses for one
// cycle with o_phase carrying the updated phase. There is no backpressure.
//   i_clk, i_rst_n   : clock, async active-low reset (release synchronised inside)
//   i_enable         : loop run enable
//   i_clear          : synchronous clear of the loop state
//   i_valid          : sample strobe; i_real / i_imag signed Q1.(NB_DATA-1)
//   o_valid, o_phase : phase strobe and estimate (full scale = 2*pi, wraps)
//   o_lock           : lock indication
module phase_tracker
  import phase_tracker_pkg::*;
#(
  parameter int                    NB_DATA            = DEF_NB_DATA,
  parameter int                    NB_PHASE           = DEF_NB_PHASE,
  parameter int                    NB_INTEG           = DEF_NB_INTEG,
  parameter int                    KP_SHIFT           = DEF_KP_SHIFT,
  parameter int                    KI_SHIFT           = DEF_KI_SHIFT,
  parameter int                    LOCKED_EXTRA_SHIFT = DEF_LOCKED_EXTRA_SHIFT,
  parameter logic [NB_PHASE-1:0]   INIT_PHASE         = DEF_INIT_PHASE,
  parameter logic [NB_DATA-1:0]    LOCK_THR           = DEF_LOCK_THR,
  parameter int                    LOCK_CNT           = DEF_LOCK_CNT,
  parameter int                    UNLOCK_CNT         = DEF_UNLOCK_CNT
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_enable,
  input  logic                       i_clear,
  input  logic                       i_valid,
  input  logic signed [NB_DATA-1:0]  i_real,
  input  logic signed [NB_DATA-1:0]  i_imag,
  output logic                       o_valid,
  output logic [NB_PHASE-1:0]        o_phase,
  output logic                       o_lock
);

  localparam int EXT = NB_INTEG + 1 - NB_DATA;
  localparam logic signed [NB_DATA-1:0]  DATA_MAX  = {1'b0, {(NB_DATA-1){1'b1}}};
  localparam logic signed [NB_DATA-1:0]  DATA_MIN  = {1'b1, {(NB_DATA-1){1'b0}}};
  localparam logic signed [NB_INTEG-1:0] INTEG_MAX = {1'b0, {(NB_INTEG-1){1'b1}}};
  localparam logic signed [NB_INTEG-1:0] INTEG_MIN = {1'b1, {(NB_INTEG-1){1'b0}}};
  localparam logic signed [NB_INTEG:0]   CTRL_HI   = {{EXT{1'b0}}, DATA_MAX};
  localparam logic signed [NB_INTEG:0]   CTRL_LO   = {{EXT{1'b1}}, DATA_MIN};

  // Reset is asserted asynchronously but released through two flops so
  // every loop register leaves reset on the same clean edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n_int = rst_sync_q[1];

  // Loop registers
  logic signed [NB_INTEG-1:0] integ_q, integ_d;
  logic [NB_PHASE-1:0]        phase_q, phase_d;
  logic                       o_valid_q, o_valid_d;
  logic [NB_PHASE-1:0]        o_phase_q, o_phase_d;

  // Datapath nets
  logic                       accept;
  logic signed [NB_DATA-1:0]  err;
  logic signed [NB_DATA:0]    err_w;
  logic [NB_DATA:0]           abs_err;
  logic                       in_thr;
  logic                       locked;
  int                         ki_sh, kp_sh;
  logic signed [NB_INTEG:0]   err_ext, err_ki, err_kp;
  logic signed [NB_INTEG:0]   integ_sum;
  logic signed [NB_INTEG-1:0] integ_next;
  logic signed [NB_INTEG:0]   ctrl_sum;
  logic signed [NB_DATA-1:0]  ctrl;
  logic [NB_PHASE-1:0]        ctrl_ext;
  logic [NB_PHASE-1:0]        phase_next;
  lock_state_e                lock_state;

  always_comb begin
    accept = i_valid & i_enable & ~i_clear;

    // Phase error: imag rotated into the right half-plane. Negating the most
    // negative value would wrap, so it saturates to the positive maximum.
    if (!i_real[NB_DATA-1])         err = i_imag;
    else if (i_imag == DATA_MIN)    err = DATA_MAX;
    else                            err = -i_imag;

    err_w   = {err[NB_DATA-1], err};
    abs_err = err_w[NB_DATA] ? (-err_w) : err_w;
    in_thr  = abs_err < {1'b0, LOCK_THR};

    // Narrower loop bandwidth once locked; IDLE uses acquisition gains.
    locked = (lock_state == ST_LOCKED);
    ki_sh  = KI_SHIFT + (locked ? LOCKED_EXTRA_SHIFT : 0);
    kp_sh  = KP_SHIFT + (locked ? LOCKED_EXTRA_SHIFT : 0);

    err_ext = {{EXT{err[NB_DATA-1]}}, err};
    err_ki  = err_ext >>> ki_sh;
    err_kp  = err_ext >>> kp_sh;

    // One guard bit: overflow shows as the two top bits disagreeing.
    integ_sum = {integ_q[NB_INTEG-1], integ_q} + err_ki;
    if (integ_sum[NB_INTEG] != integ_sum[NB_INTEG-1])
      integ_next = integ_sum[NB_INTEG] ? INTEG_MIN : INTEG_MAX;
    else
      integ_next = integ_sum[NB_INTEG-1:0];

    ctrl_sum = err_kp + {integ_next[NB_INTEG-1], integ_next};
    if (ctrl_sum > CTRL_HI)      ctrl = DATA_MAX;
    else if (ctrl_sum < CTRL_LO) ctrl = DATA_MIN;
    else                         ctrl = ctrl_sum[NB_DATA-1:0];

    // Modular add: phase wraps around 2*pi on purpose.
    phase_next = phase_q + ctrl_ext;
  end

  if (NB_PHASE > NB_DATA) begin : g_ctrl_sext
    assign ctrl_ext = {{(NB_PHASE-NB_DATA){ctrl[NB_DATA-1]}}, ctrl};
  end else begin : g_ctrl_trunc
    assign ctrl_ext = ctrl[NB_PHASE-1:0];
  end

  always_comb begin
    integ_d   = integ_q;
    phase_d   = phase_q;
    o_valid_d = 1'b0;
    o_phase_d = o_phase_q;
    if (i_clear) begin
      integ_d   = '0;
      phase_d   = INIT_PHASE;
      o_phase_d = INIT_PHASE;
    end else if (accept) begin
      integ_d   = integ_next;
      phase_d   = phase_next;
      o_valid_d = 1'b1;
      o_phase_d = phase_next;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      integ_q   <= '0;
      phase_q   <= INIT_PHASE;
      o_valid_q <= 1'b0;
      o_phase_q <= INIT_PHASE;
    end else begin
      integ_q   <= integ_d;
      phase_q   <= phase_d;
      o_valid_q <= o_valid_d;
      o_phase_q <= o_phase_d;
    end
  end

  lock_detector #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) u_lock_detector (
    .i_clk       (i_clk),
    .i_rst_n     (rst_n_int),
    .i_enable    (i_enable),
    .i_clear     (i_clear),
    .i_sample    (accept),
    .i_in_thr    (in_thr),
    .o_lock      (o_lock),
    .o_dbg_state (lock_state)
  );

  assign o_valid = o_valid_q;
  assign o_phase = o_phase_q;

endmodule

// File: tb/tb_phase_tracker.sv
// Directed bench for phase_tracker: reset values, single-sample loop math,
// saturation, negative error, phase wrap, lock/unlock counting, enable and
// clear behaviour, and asynchronous reset mid-run.
module tb_phase_tracker;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic        valid;
  logic [15:0] s_real;
  logic [15:0] s_imag;

  logic        o_valid, o_lock;
  logic [15:0] o_phase;
  logic        o_valid_w, o_lock_w;
  logic [15:0] o_phase_w;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  phase_tracker dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_enable (enable),
    .i_clear  (clear),
    .i_valid  (valid),
    .i_real   (s_real),
    .i_imag   (s_imag),
    .o_valid  (o_valid),
    .o_phase  (o_phase),
    .o_lock   (o_lock)
  );

  // Same stimulus, phase starting just below the wrap point.
  phase_tracker #(.INIT_PHASE(16'hFFF0)) dut_wrap (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_enable (enable),
    .i_clear  (clear),
    .i_valid  (valid),
    .i_real   (s_real),
    .i_imag   (s_imag),
    .o_valid  (o_valid_w),
    .o_phase  (o_phase_w),
    .o_lock   (o_lock_w)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drives one sample for one cycle; returns on the following negedge,
  // where the registered response is visible.
  task automatic send_sample(input logic [15:0] re, input logic [15:0] im);
    @(negedge clk);
    valid  = 1'b1;
    s_real = re;
    s_imag = im;
    @(negedge clk);
    valid  = 1'b0;
  endtask

  task automatic do_clear(input logic with_valid);
    @(negedge clk);
    clear  = 1'b1;
    valid  = with_valid;
    s_real = 16'h4000;
    s_imag = 16'h0400;
    @(negedge clk);
    clear  = 1'b0;
    valid  = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    clear  = 1'b0;
    valid  = 1'b0;
    s_real = '0;
    s_imag = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_phase", o_phase, 16'h0CCC);
    check_eq("rst_valid", o_valid, 1'b0);
    check_eq("rst_lock", o_lock, 1'b0);
    check_eq("rst_phase_wrap", o_phase_w, 16'hFFF0);

    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // err=0x400, integ=1, ctrl=0x41
    send_sample(16'h4000, 16'h0400);
    check_eq("s1_valid", o_valid, 1'b1);
    check_eq("s1_phase", o_phase, 16'h0D0D);
    check_eq("s1_lock", o_lock, 1'b0);
    check_eq("s1_phase_wrap", o_phase_w, 16'h0031);
    @(negedge clk);
    check_eq("s1_valid_drop", o_valid, 1'b0);
    check_eq("s1_phase_hold", o_phase, 16'h0D0D);

    // Clear without sample
    do_clear(1'b0);
    check_eq("clr_phase", o_phase, 16'h0CCC);
    check_eq("clr_valid", o_valid, 1'b0);

    // Saturated error: err=0x7FFF, integ=31, ctrl=2047+31=0x81E
    send_sample(16'hFFFF, 16'h8000);
    check_eq("sat_valid", o_valid, 1'b1);
    check_eq("sat_phase", o_phase, 16'h14EA);

    // Negative error: err=-1024, integ=-1, ctrl=-65
    do_clear(1'b0);
    send_sample(16'hC000, 16'h0400);
    check_eq("neg_phase", o_phase, 16'h0C8B);

    // Lock acquisition: 64 zero-error samples
    do_clear(1'b0);
    for (int i = 1; i <= 64; i++) begin
      send_sample(16'h4000, 16'h0000);
      if (i == 63) check_eq("lock_63", o_lock, 1'b0);
      if (i == 64) begin
        check_eq("lock_64", o_lock, 1'b1);
        check_eq("lock_64_valid", o_valid, 1'b1);
        check_eq("lock_64_phase", o_phase, 16'h0CCC);
      end
    end

    // 7 out-of-threshold samples: locked gains give ctrl=0x20 each, no drop
    for (int i = 1; i <= 7; i++) send_sample(16'h4000, 16'h0800);
    check_eq("bad7_lock", o_lock, 1'b1);
    check_eq("bad7_phase", o_phase, 16'h0DAC);

    // In-threshold sample restarts the unlock count
    send_sample(16'h4000, 16'h0000);
    check_eq("good_lock", o_lock, 1'b1);

    for (int i = 1; i <= 8; i++) begin
      send_sample(16'h4000, 16'h0800);
      if (i == 7) check_eq("unlock_7", o_lock, 1'b1);
      if (i == 8) begin
        check_eq("unlock_8", o_lock, 1'b0);
        check_eq("unlock_8_valid", o_valid, 1'b1);
        check_eq("unlock_8_phase", o_phase, 16'h0EAC);
      end
    end

    // Sample while disabled is dropped
    @(negedge clk);
    enable = 1'b0;
    send_sample(16'h4000, 16'h0400);
    check_eq("dis_valid", o_valid, 1'b0);
    check_eq("dis_phase", o_phase, 16'h0EAC);
    check_eq("dis_lock", o_lock, 1'b0);
    enable = 1'b1;

    // Relock, nudge phase, then clear together with a sample
    do_clear(1'b0);
    for (int i = 1; i <= 64; i++) send_sample(16'h4000, 16'h0000);
    check_eq("relock", o_lock, 1'b1);
    send_sample(16'h4000, 16'h0800);
    check_eq("relock_nudge_phase", o_phase, 16'h0CEC);
    do_clear(1'b1);
    check_eq("clrv_valid", o_valid, 1'b0);
    check_eq("clrv_phase", o_phase, 16'h0CCC);
    check_eq("clrv_lock", o_lock, 1'b0);

    // Asynchronous reset mid-run
    send_sample(16'h4000, 16'h0400);
    check_eq("pre_rst_phase", o_phase, 16'h0D0D);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_phase", o_phase, 16'h0CCC);
    check_eq("async_rst_valid", o_valid, 1'b0);
    check_eq("async_rst_lock", o_lock, 1'b0);

    exp_q.delete();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
